// File: rtl/host_cmd_master_if.sv
// Command/response handshake and UART lines of the host command master.
interface host_cmd_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_wdata;
   logic [7:0]  cmd_op_a;
   logic [7:0]  cmd_op_b;
   logic [7:0]  cmd_func;
   logic        tx_out;
   logic        rx_in;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_par_err;
   logic        rsp_stp_err;
   logic        rsp_timeout;
   logic        busy;

   modport master (
      output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_func, rx_in,
      input  cmd_ready, tx_out, rsp_valid, rsp_data, rsp_par_err, rsp_stp_err, rsp_timeout, busy
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_func, rx_in,
      output cmd_ready, tx_out, rsp_valid, rsp_data, rsp_par_err, rsp_stp_err, rsp_timeout, busy
   );
endinterface

// File: rtl/host_cmd_master.sv
// Host command master: serialises a latched command as UART frames (8E1) and
// collects up to two response bytes with parity, stop-bit and timeout checking.
module host_cmd_master #(
   parameter int PRESCALE    = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic             CLK,
   input  logic             RST,
   host_cmd_master_if.slave bus
);
   localparam int PW = $clog2(PRESCALE) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [PW-1:0] BIT_LAST  = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] HALF_LAST = PW'(PRESCALE / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, TX_FRAME, RX_WAIT, RX_FRAME, DONE} state_t;

   state_t        state_q;
   logic [7:0]    tx_byte_q [4];
   logic [1:0]    tx_last_q;
   logic [1:0]    tx_idx_q;
   logic [1:0]    rx_exp_q;
   logic [1:0]    rx_cnt_q;
   logic [3:0]    bit_q;
   logic [PW-1:0] presc_q;
   logic [TW-1:0] to_q;
   logic [7:0]    rx_sh_q;
   logic          tx_q;
   logic [15:0]   rsp_data_q;
   logic          par_err_q;
   logic          stp_err_q;
   logic          timeout_q;

   // Bit idx of an 11-bit frame: start, d0..d7, even parity, stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
      logic [10:0] f;
      f = {1'b1, ^b, b, 1'b0};
      return f[idx];
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         tx_q       <= 1'b1;
         rsp_data_q <= '0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
         tx_last_q  <= '0;
         tx_idx_q   <= '0;
         rx_exp_q   <= '0;
         rx_cnt_q   <= '0;
         bit_q      <= '0;
         presc_q    <= '0;
         to_q       <= '0;
         rx_sh_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  rsp_data_q <= '0;
                  par_err_q  <= 1'b0;
                  stp_err_q  <= 1'b0;
                  timeout_q  <= 1'b0;
                  tx_idx_q   <= '0;
                  rx_cnt_q   <= '0;
                  bit_q      <= '0;
                  presc_q    <= '0;
                  tx_q       <= 1'b0;
                  state_q    <= TX_FRAME;
                  unique case (bus.cmd_type)
                     2'b00: begin
                        tx_byte_q[0] <= 8'hAA;         tx_byte_q[1] <= bus.cmd_addr;
                        tx_byte_q[2] <= bus.cmd_wdata; tx_byte_q[3] <= 8'h00;
                        tx_last_q    <= 2'd2;          rx_exp_q     <= 2'd0;
                     end
                     2'b01: begin
                        tx_byte_q[0] <= 8'hBB;         tx_byte_q[1] <= bus.cmd_addr;
                        tx_byte_q[2] <= 8'h00;         tx_byte_q[3] <= 8'h00;
                        tx_last_q    <= 2'd1;          rx_exp_q     <= 2'd1;
                     end
                     2'b10: begin
                        tx_byte_q[0] <= 8'hCC;         tx_byte_q[1] <= bus.cmd_op_a;
                        tx_byte_q[2] <= bus.cmd_op_b;  tx_byte_q[3] <= bus.cmd_func;
                        tx_last_q    <= 2'd3;          rx_exp_q     <= 2'd2;
                     end
                     2'b11: begin
                        tx_byte_q[0] <= 8'hDD;         tx_byte_q[1] <= bus.cmd_func;
                        tx_byte_q[2] <= 8'h00;         tx_byte_q[3] <= 8'h00;
                        tx_last_q    <= 2'd1;          rx_exp_q     <= 2'd2;
                     end
                  endcase
               end
            end
            TX_FRAME: begin
               if (presc_q == BIT_LAST) begin
                  presc_q <= '0;
                  if (bit_q == 4'd10) begin
                     bit_q <= '0;
                     if (tx_idx_q == tx_last_q) begin
                        tx_q    <= 1'b1;
                        to_q    <= '0;
                        state_q <= (rx_exp_q == 2'd0) ? IDLE : RX_WAIT;
                     end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        tx_idx_q <= tx_idx_q + 2'd1;
                        tx_q     <= 1'b0;
                     end
                  end else begin
                     bit_q <= bit_q + 4'd1;
                     tx_q  <= frame_bit(tx_byte_q[tx_idx_q], bit_q + 4'd1);
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            RX_WAIT: begin
               if (!bus.rx_in) begin
                  presc_q <= '0;
                  bit_q   <= '0;
                  state_q <= RX_FRAME;
               end else if (to_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  to_q <= to_q + TW'(1);
               end
            end
            RX_FRAME: begin
               // First sample lands mid start bit, later ones a full bit apart.
               if (presc_q == ((bit_q == 4'd0) ? HALF_LAST : BIT_LAST)) begin
                  presc_q <= '0;
                  bit_q   <= bit_q + 4'd1;
                  if (bit_q == 4'd0) begin
                     if (bus.rx_in) begin
                        to_q    <= '0;
                        state_q <= RX_WAIT;
                     end
                  end else if (bit_q <= 4'd8) begin
                     rx_sh_q <= {bus.rx_in, rx_sh_q[7:1]};
                  end else if (bit_q == 4'd9) begin
                     if (bus.rx_in != ^rx_sh_q) par_err_q <= 1'b1;
                  end else begin
                     if (!bus.rx_in) stp_err_q <= 1'b1;
                     if (rx_cnt_q == 2'd0) rsp_data_q[7:0]  <= rx_sh_q;
                     else                  rsp_data_q[15:8] <= rx_sh_q;
                     rx_cnt_q <= rx_cnt_q + 2'd1;
                     if (rx_cnt_q + 2'd1 == rx_exp_q) begin
                        state_q <= DONE;
                     end else begin
                        to_q    <= '0;
                        state_q <= RX_WAIT;
                     end
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.tx_out      = tx_q;
   assign bus.rsp_valid   = (state_q == DONE);
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_par_err = par_err_q;
   assign bus.rsp_stp_err = stp_err_q;
   assign bus.rsp_timeout = timeout_q;
endmodule

// File: tb/tb_host_cmd_master.sv
// Bench for host_cmd_master: directed and randomized commands, TX frames decoded
// from tx_out and responses driven on rx_in, checked against a frame-level model.
module tb_host_cmd_master;
   localparam int P = 8;
   localparam int T = 256;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   host_cmd_master_if bus();

   host_cmd_master #(.PRESCALE(P), .TIMEOUT_CYC(T)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int          n_vec  = 0;
   int          n_err  = 0;
   int          cyc    = 0;
   int          rv_cnt = 0;
   int          rv_cyc = 0;
   logic [15:0] rv_data = '0;
   logic [2:0]  rv_flags = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Record every cycle on which a response is presented.
   always @(negedge CLK) begin
      if (bus.rsp_valid === 1'b1) begin
         rv_cnt   <= rv_cnt + 1;
         rv_cyc   <= cyc;
         rv_data  <= bus.rsp_data;
         rv_flags <= {bus.rsp_par_err, bus.rsp_stp_err, bus.rsp_timeout};
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] uart_frame(input logic [7:0] b, input logic bad_par, input logic bad_stp);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) p = p ^ b[i];
      return {~bad_stp, p ^ bad_par, b, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic bp, input logic bs);
      logic [10:0] f;
      f = uart_frame(b, bp, bs);
      for (int j = 0; j < 11; j++) begin
         bus.rx_in = f[j];
         repeat (P) @(negedge CLK);
      end
      bus.rx_in = 1'b1;
   endtask

   task automatic scramble_payload();
      bus.cmd_type  = 2'($urandom);
      bus.cmd_addr  = 8'($urandom);
      bus.cmd_wdata = 8'($urandom);
      bus.cmd_op_a  = 8'($urandom);
      bus.cmd_op_b  = 8'($urandom);
      bus.cmd_func  = 8'($urandom);
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] t,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                          input int nsend, input logic [7:0] r0, input logic [7:0] r1,
                          input logic [1:0] bad_par, input logic [1:0] bad_stp,
                          input int gap0, input bit glitch, input bit chk_time);
      logic [7:0]  txb[$];
      logic [7:0]  rb[2];
      logic [10:0] frm;
      logic [15:0] exp_data;
      logic [2:0]  exp_flags;
      int          nrsp, base, acc;

      case (t)
         2'b00:   begin txb = '{8'hAA, addr, wdata}; nrsp = 0; end
         2'b01:   begin txb = '{8'hBB, addr};        nrsp = 1; end
         2'b10:   begin txb = '{8'hCC, a, b, f};     nrsp = 2; end
         default: begin txb = '{8'hDD, f};           nrsp = 2; end
      endcase
      rb[0] = r0;
      rb[1] = r1;

      for (int i = 0; i < 200 && bus.cmd_ready !== 1'b1; i++) @(negedge CLK);
      check({tag, ":ready_in"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_type  = t;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_op_a  = a;
      bus.cmd_op_b  = b;
      bus.cmd_func  = f;
      bus.cmd_valid = 1'b1;
      @(negedge CLK);
      acc  = cyc;
      base = rv_cnt;
      check({tag, ":accept"}, 32'(bus.busy), 32'd1);
      check({tag, ":txstart"}, 32'(bus.tx_out), 32'd0);
      bus.cmd_valid = 1'b0;
      scramble_payload();

      frm = '0;
      for (int g = 0; g < 11 * txb.size(); g++) begin
         repeat ((g == 0) ? P / 2 : P) @(negedge CLK);
         frm[g % 11] = bus.tx_out;
         if (g == 5) begin
            bus.cmd_valid = 1'b1;
            scramble_payload();
         end
         if (g == 6) bus.cmd_valid = 1'b0;
         if (g % 11 == 10)
            check($sformatf("%s:frame%0d", tag, g / 11), 32'(frm),
                  32'(uart_frame(txb[g / 11], 1'b0, 1'b0)));
      end

      if (nrsp == 0) begin
         repeat (P / 2 - 1) @(negedge CLK);
         check({tag, ":busy_end"}, 32'(bus.busy), 32'd1);
         @(negedge CLK);
         check({tag, ":ready_end"}, 32'(bus.cmd_ready), 32'd1);
         repeat (4) @(negedge CLK);
         check({tag, ":no_rsp"}, 32'(rv_cnt - base), 32'd0);
         return;
      end
      repeat (P / 2) @(negedge CLK);

      for (int k = 0; k < nsend; k++) begin
         repeat ((k == 0) ? gap0 : int'($urandom_range(1, 12))) @(negedge CLK);
         if (glitch && k == 0) begin
            bus.rx_in = 1'b0;
            repeat ($urandom_range(1, P / 2 - 1)) @(negedge CLK);
            bus.rx_in = 1'b1;
            repeat (P) @(negedge CLK);
         end
         send_byte(rb[k], bad_par[k], bad_stp[k]);
      end
      bus.rx_in = 1'b1;

      for (int i = 0; i < T + 4 * P && rv_cnt == base; i++) @(negedge CLK);
      @(negedge CLK);
      check({tag, ":rsp_pulses"}, 32'(rv_cnt - base), 32'd1);

      exp_data  = '0;
      exp_flags = '0;
      for (int k = 0; k < nsend; k++) begin
         if (k == 0) exp_data[7:0]  = rb[0];
         else        exp_data[15:8] = rb[1];
         exp_flags[2] = exp_flags[2] | bad_par[k];
         exp_flags[1] = exp_flags[1] | bad_stp[k];
      end
      exp_flags[0] = (nsend < nrsp);
      check({tag, ":rsp_data"}, 32'(rv_data), 32'(exp_data));
      check({tag, ":rsp_flags"}, 32'(rv_flags), 32'(exp_flags));
      if (chk_time)
         check({tag, ":to_latency"}, 32'(rv_cyc - acc), 32'(11 * txb.size() * P + T));
      repeat (3) @(negedge CLK);
      check({tag, ":hold"}, {15'd0, bus.rsp_valid, bus.rsp_data}, {16'd0, exp_data});
      check({tag, ":ready_after"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] t;
      logic [1:0] bp, bs;
      int         nrsp, nsend;

      bus.cmd_valid = 1'b0;
      bus.rx_in     = 1'b1;
      scramble_payload();
      repeat (3) @(negedge CLK);
      check("rst:tx_out", 32'(bus.tx_out), 32'd1);
      check("rst:ready_busy", {bus.cmd_ready, bus.busy}, 32'b10);
      check("rst:rsp", {bus.rsp_valid, bus.rsp_data}, 32'd0);
      check("rst:flags", {bus.rsp_par_err, bus.rsp_stp_err, bus.rsp_timeout}, 32'd0);
      RST = 1'b0;

      // rx activity while idle must not start anything
      repeat (2) @(negedge CLK);
      bus.rx_in = 1'b0;
      repeat (2 * P) @(negedge CLK);
      bus.rx_in = 1'b1;
      repeat (2) @(negedge CLK);
      check("idle_rx", {bus.busy, rv_cnt[30:0]}, 32'd0);

      run_cmd("rfwr", 2'b00, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1'b0, 1'b0);
      run_cmd("rfrd", 2'b01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h5A, 8'h00, 2'b00, 2'b00, 20, 1'b0, 1'b0);
      run_cmd("aluop", 2'b10, 8'h00, 8'h00, 8'h5A, 8'h2F, 8'h00, 2, 8'h89, 8'h00, 2'b00, 2'b00, 7, 1'b0, 1'b0);
      run_cmd("rd_to", 2'b01, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 1'b0, 1'b1);
      run_cmd("rd_glitch", 2'b01, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'hC3, 8'h00, 2'b00, 2'b00, 5, 1'b1, 1'b0);
      run_cmd("alunop", 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 2, 8'h34, 8'h12, 2'b01, 2'b10, 9, 1'b0, 1'b0);

      // reset during the start bit of the second frame of an ALU_OP
      bus.cmd_type  = 2'b10;
      bus.cmd_op_a  = 8'h11;
      bus.cmd_op_b  = 8'h22;
      bus.cmd_func  = 8'h01;
      bus.cmd_valid = 1'b1;
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      check("rstmid:accept", 32'(bus.busy), 32'd1);
      repeat (11 * P + 2) @(negedge CLK);
      check("rstmid:pre_tx", 32'(bus.tx_out), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("rstmid:tx_ready", {bus.tx_out, bus.cmd_ready, bus.busy}, 32'b110);
      check("rstmid:rsp", {bus.rsp_valid, bus.rsp_par_err, bus.rsp_stp_err, bus.rsp_timeout, bus.rsp_data}, 32'd0);
      begin
         int base;
         base = rv_cnt;
         repeat (3 * P) @(negedge CLK);
         check("rstmid:quiet", {bus.tx_out, 31'(rv_cnt - base)}, 32'h8000_0000);
      end
      run_cmd("rstmid:rd", 2'b01, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 8'h00, 2'b00, 2'b00, 4, 1'b0, 1'b0);

      for (int it = 0; it < 12; it++) begin
         t     = 2'($urandom);
         nrsp  = (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : 2;
         nsend = nrsp;
         if (nrsp > 0 && $urandom_range(0, 3) == 0) nsend = $urandom_range(0, nrsp - 1);
         bp = 2'($urandom);
         bs = 2'b00;
         if (nsend == nrsp && nsend > 0 && $urandom_range(0, 1) == 1) bs[nsend - 1] = 1'b1;
         run_cmd($sformatf("rnd%0d", it), t, 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), nsend, 8'($urandom), 8'($urandom), bp, bs,
                 $urandom_range(1, 40), 1'($urandom), (nsend == 0) ? 1'b1 : 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 Parameter PRESCALE, default 8: CLK cycles per UART bit; legal values are even numbers >= 4.
REQ-002 Parameter TIMEOUT_CYC, default 4096: maximum CLK cycles to wait for each response start bit.
REQ-003 Port CLK  in  1: single clock for the block; all state updates on the rising edge.
REQ-004 Port RST  in  1: reset, synchronous and active-high.
REQ-005 Port cmd_valid  in  1: command request, accepted on a cycle where cmd_ready=1.
REQ-006 Port cmd_ready  out  1: high only in IDLE.
REQ-007 Port cmd_type  in  2: command type.
  - 00: RF_WR
  - 01: RF_RD
  - 10: ALU_OP
  - 11: ALU_NOP
REQ-008 Ports cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_func  in  8 each: command payload bytes.
REQ-009 Port tx_out  out  1: UART serial line to the system; idle level is 1.
REQ-010 Port rx_in  in  1: UART serial line from the system; already synchronous to CLK.
REQ-011 Port rsp_valid  out  1: one-cycle pulse marking completion of a command that expects a response.
REQ-012 Port rsp_data  out  16: response data; the first received byte goes to [7:0].
REQ-013 Ports rsp_par_err, rsp_stp_err, rsp_timeout  out  1 each: error flags, valid while rsp_valid=1.
REQ-014 Port busy  out  1: equal to the inverse of cmd_ready.

Function
REQ-015 Frame format SHALL be 11 bits, sent in this order:
  - start bit 0
  - 8 data bits, LSB first
  - even parity bit (XOR of the data bits)
  - stop bit 1
  - each bit lasts PRESCALE cycles
REQ-016 On acceptance, the block SHALL latch all payload inputs; later changes to the inputs SHALL have no effect.
REQ-017 The TX byte sequence per command type SHALL be:
  - RF_WR: 0xAA, addr, wdata
  - RF_RD: 0xBB, addr
  - ALU_OP: 0xCC, op_a, op_b, func
  - ALU_NOP: 0xDD, func
REQ-018 Frames SHALL be sent back-to-back with no idle bit between them; the tx_out start bit SHALL begin on the cycle after acceptance.
REQ-019 Expected response byte counts SHALL be: RF_WR 0, RF_RD 1, ALU_OP 2, ALU_NOP 2.
REQ-020 The state machine SHALL have states IDLE, TX_FRAME, RX_WAIT, RX_FRAME, DONE.
  - IDLE -> TX_FRAME on acceptance.
  - TX_FRAME -> IDLE after the last stop bit if 0 responses are expected.
  - TX_FRAME -> RX_WAIT after the last stop bit otherwise.
  - RX_WAIT -> RX_FRAME on rx_in=0.
  - RX_FRAME -> RX_WAIT after the stop-bit sample if more bytes remain.
  - RX_FRAME -> DONE after the stop-bit sample of the last byte.
  - RX_WAIT -> DONE when the timeout counter reaches TIMEOUT_CYC-1.
  - DONE -> IDLE after 1 cycle.
REQ-021 RX sampling SHALL take place PRESCALE/2 cycles after the falling edge, then every PRESCALE cycles (start, d0..d7, parity, stop).
REQ-022 If the start bit samples as 1, the block SHALL treat it as a glitch and return to RX_WAIT without counting a byte.
REQ-023 rsp_par_err SHALL be set if the received parity differs from the even parity of the received data, for any response byte; it is sticky for the command.
REQ-024 rsp_stp_err SHALL be set if any sampled stop bit is 0; it is sticky for the command.
REQ-025 The timeout counter SHALL clear on entry to RX_WAIT; on timeout, rsp_timeout=1 and unreceived bytes of rsp_data read 0.
REQ-026 rsp_valid SHALL be high only in DONE; rsp_data and the error flags SHALL hold their values until the next acceptance.
REQ-027 rx_in activity outside RX_WAIT/RX_FRAME SHALL be ignored.
REQ-028 cmd_valid while busy SHALL be ignored; the command is not queued.

Reset
REQ-029 While RST=1 at a CLK edge, the block SHALL enter IDLE with these output values:
  - tx_out=1, cmd_ready=1, busy=0
  - rsp_valid=0, rsp_data=0
  - rsp_par_err=0, rsp_stp_err=0, rsp_timeout=0
REQ-030 Reset asserted mid-frame SHALL abort the transfer immediately; tx_out returns to 1 on the next cycle and no rsp_valid is produced.

Verification
REQ-031 RF_WR, addr 0x01, wdata 0x5A -> tx_out carries frames 0xAA (parity 0), 0x01 (parity 1), 0x5A (parity 0) in 33*PRESCALE cycles; then cmd_ready=1 and no rsp_valid.
REQ-032 RF_RD, addr 0x01; bench replies with frame 0x5A after 20 cycles -> rsp_valid with rsp_data=0x005A and all error flags 0.
REQ-033 ALU_OP, op_a 0x5A, op_b 0x2F, func 0x00; bench replies 0x89 then 0x00 -> rsp_data=0x0089.
REQ-034 ALU_NOP, func 0x02; bench replies 0x34 with wrong parity, then 0x12 with stop bit 0 -> rsp_data=0x1234, rsp_par_err=1, rsp_stp_err=1.
REQ-035 RF_RD with rx_in held at 1 -> rsp_valid exactly TIMEOUT_CYC cycles after entering RX_WAIT, with rsp_timeout=1 and rsp_data=0.
REQ-036 RST pulsed during the second TX frame of an ALU_OP -> tx_out=1 the next cycle and cmd_ready=1; a following RF_RD completes normally.
